main_mem_burst: RTL and testbench

MAIN_MEM_BURST -- requirements
Module: main_mem_burst

---
 rtl/main_mem_burst_if.sv | 31 +++
 rtl/main_mem_burst.sv | 158 +++++++++++++++
 tb/tb_main_mem_burst.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/main_mem_burst_if.sv
// Request, write-beat and read-beat signals of the burst memory, bundled so the
// memory and its requester connect through a single port.
interface main_mem_burst_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic              wr_valid;
    logic              wr_ready;
    logic [DATA_W-1:0] wr_data;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic              rd_last;
    logic              wr_done;
    logic              busy;

    // Requester side: issues line requests and write beats, consumes read beats.
    modport master (
        output req_valid, req_write, req_addr, wr_valid, wr_data,
        input  req_ready, wr_ready, rd_valid, rd_data, rd_last, wr_done, busy
    );

    // Memory side.
    modport slave (
        input  req_valid, req_write, req_addr, wr_valid, wr_data,
        output req_ready, wr_ready, rd_valid, rd_data, rd_last, wr_done, busy
    );
endinterface

// File: rtl/main_mem_burst.sv
// Line-oriented burst memory with a fixed access latency. Each request moves a
// whole aligned line of BURST_LEN words, starting at the critical word and
// wrapping within the line. Reads wait LAT cycles and then stream the line with
// no backpressure; writes take beats as they arrive and then wait LAT cycles
// before reporting completion with a single-cycle wr_done.
module main_mem_burst #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int BURST_LEN = 4,
    parameter int LAT       = 4
) (
    input logic             clk,
    input logic             rst_n,
    main_mem_burst_if.slave bus
);

    localparam int DEPTH = 2 ** ADDR_W;
    // Beat counter runs 0..BURST_LEN inclusive, so it needs one value beyond the line.
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    // Latency counter only ever holds 0..LAT-1.
    localparam int LAT_W = (LAT > 1) ? $clog2(LAT) : 1;

    localparam logic [CNT_W-1:0]  BEAT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [CNT_W-1:0]  BEAT_END  = CNT_W'(BURST_LEN);
    localparam logic [LAT_W-1:0]  LAT_LAST  = LAT_W'((LAT > 0) ? LAT - 1 : 0);
    localparam logic [ADDR_W-1:0] OFF_MASK  = ADDR_W'(BURST_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        RWAIT,
        RBURST,
        WBURST,
        WWAIT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [CNT_W-1:0]  beat_cnt;
    logic [LAT_W-1:0]  lat_cnt;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] beat_addr;
    logic              accept;
    logic              wr_beat;

    // Two-state storage: powers up all-zero and is deliberately outside the reset
    // domain, so committed writes survive a reset.
    bit [DATA_W-1:0] mem [DEPTH];

    // Request handshake and write-beat handshake qualifiers.
    always_comb begin
        accept  = bus.req_valid && bus.req_ready;
        wr_beat = (state == WBURST) && bus.wr_valid;
    end

    // Beat address: line base from the request, offset wraps within the line.
    always_comb begin
        beat_addr = (addr_q & ~OFF_MASK) | ((addr_q + ADDR_W'(beat_cnt)) & OFF_MASK);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic. RBURST lingers one cycle after issuing its final beat so
    // the last beat is on the outputs before the block reports idle again.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (bus.req_write) begin
                        state_next = WBURST;
                    end else if (LAT == 0) begin
                        state_next = RBURST;
                    end else begin
                        state_next = RWAIT;
                    end
                end
            end
            RWAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    state_next = RBURST;
                end
            end
            RBURST: begin
                if (beat_cnt == BEAT_END) begin
                    state_next = IDLE;
                end
            end
            WBURST: begin
                if (wr_beat && (beat_cnt == BEAT_LAST)) begin
                    state_next = (LAT == 0) ? IDLE : WWAIT;
                end
            end
            WWAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State-decoded handshake and status outputs.
    always_comb begin
        bus.req_ready = (state == IDLE) && rst_n;
        bus.wr_ready  = (state == WBURST);
        bus.busy      = (state != IDLE);
    end

    // Counters, captured request address, read-beat register and completion pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt    <= '0;
            lat_cnt     <= '0;
            addr_q      <= '0;
            bus.rd_valid <= 1'b0;
            bus.rd_last  <= 1'b0;
            bus.rd_data  <= '0;
            bus.wr_done  <= 1'b0;
        end else begin
            bus.rd_valid <= 1'b0;
            bus.rd_last  <= 1'b0;
            bus.wr_done  <= ((state == WBURST) || (state == WWAIT)) && (state_next == IDLE);

            if (accept) begin
                addr_q   <= bus.req_addr;
                beat_cnt <= '0;
            end else if ((state == RBURST) && (beat_cnt != BEAT_END)) begin
                beat_cnt     <= beat_cnt + CNT_W'(1);
                bus.rd_valid <= 1'b1;
                bus.rd_last  <= (beat_cnt == BEAT_LAST);
                bus.rd_data  <= mem[beat_addr];
            end else if (wr_beat) begin
                beat_cnt <= beat_cnt + CNT_W'(1);
            end

            if (state_next != state) begin
                lat_cnt <= '0;
            end else if ((state == RWAIT) || (state == WWAIT)) begin
                lat_cnt <= lat_cnt + LAT_W'(1);
            end
        end
    end

    // Array write port: one word per accepted write beat.
    always_ff @(posedge clk) begin
        if (wr_beat) begin
            mem[beat_addr] <= bus.wr_data;
        end
    end

endmodule

// File: tb/tb_main_mem_burst.sv
// Directed self-checking bench for main_mem_burst: one instance at LAT=4,
// BURST_LEN=4 and one at LAT=0, BURST_LEN=1, sharing clock and reset.
module tb_main_mem_burst;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    main_mem_burst_if #(.DATA_W(8), .ADDR_W(8)) b1 ();
    main_mem_burst_if #(.DATA_W(8), .ADDR_W(8)) b2 ();

    main_mem_burst #(.DATA_W(8), .ADDR_W(8), .BURST_LEN(4), .LAT(4)) dut (
        .clk(clk), .rst_n(rst_n), .bus(b1)
    );

    main_mem_burst #(.DATA_W(8), .ADDR_W(8), .BURST_LEN(1), .LAT(0)) dut_single (
        .clk(clk), .rst_n(rst_n), .bus(b2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a request on b1 and return in the cycle after the accepting edge.
    task automatic accept_req(input logic wr, input logic [7:0] addr, input string name);
        checks++;
        if (b1.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s req_ready before accept: got %b want 1", name, b1.req_ready);
        end
        b1.req_valid = 1'b1;
        b1.req_write = wr;
        b1.req_addr  = addr;
        tick();
        b1.req_valid = 1'b0;
        b1.req_write = ~wr;
        b1.req_addr  = ~addr;
    endtask

    // Read a line on b1; exp holds beat 0 in its top byte.
    task automatic read_line(input logic [7:0] addr, input logic [31:0] exp, input string name);
        logic [7:0] want;
        accept_req(1'b0, addr, name);
        for (int n = 1; n <= 9; n++) begin
            tick();
            checks++;
            if (b1.rd_valid !== ((n >= 5) && (n <= 8))) begin
                errors++;
                $display("FAIL %s rd_valid n=%0d: got %b want %b", name, n, b1.rd_valid, (n >= 5) && (n <= 8));
            end
            checks++;
            if (b1.rd_last !== (n == 8)) begin
                errors++;
                $display("FAIL %s rd_last n=%0d: got %b want %b", name, n, b1.rd_last, n == 8);
            end
            if (n >= 5) begin
                want = (n <= 8) ? exp[31 - 8 * (n - 5) -: 8] : exp[7:0];
                checks++;
                if (b1.rd_data !== want) begin
                    errors++;
                    $display("FAIL %s rd_data n=%0d: got %h want %h", name, n, b1.rd_data, want);
                end
            end
            checks++;
            if (b1.req_ready !== (n == 9)) begin
                errors++;
                $display("FAIL %s req_ready n=%0d: got %b want %b", name, n, b1.req_ready, n == 9);
            end
        end
    endtask

    // Write n_beats of a line on b1, optionally stalling stall_len cycles once
    // stall_after beats have gone in. Junk with wr_valid high is offered after
    // the last beat and must be ignored. For a full line, wr_done must pulse
    // once, exp_done cycles after the accepting edge.
    task automatic write_line(input logic [7:0] addr, input logic [31:0] data, input int n_beats,
                              input int stall_after, input int stall_len, input int exp_done,
                              input string name);
        int   beat = 0;
        int   stall_left = stall_len;
        int   pulses = 0;
        int   done_at = -1;
        int   limit = (n_beats < 4) ? 12 : exp_done + 2;
        logic hs;
        accept_req(1'b1, addr, name);
        for (int n = 1; n <= limit; n++) begin
            if ((beat == stall_after) && (stall_left > 0)) begin
                stall_left--;
                b1.wr_valid = 1'b0;
                b1.wr_data  = 8'hEE;
            end else if (beat < n_beats) begin
                b1.wr_valid = 1'b1;
                b1.wr_data  = data[31 - 8 * beat -: 8];
            end else begin
                b1.wr_valid = 1'b1;
                b1.wr_data  = 8'hEE;
            end
            hs = b1.wr_valid && b1.wr_ready;
            tick();
            if (hs) beat++;
            if (b1.wr_done === 1'b1) begin
                pulses++;
                done_at = n;
            end
            if ((n_beats < 4) && (beat == n_beats)) break;
        end
        b1.wr_valid = 1'b0;
        checks++;
        if (beat != n_beats) begin
            errors++;
            $display("FAIL %s beats taken: got %0d want %0d", name, beat, n_beats);
        end
        if (n_beats == 4) begin
            checks++;
            if (pulses != 1) begin
                errors++;
                $display("FAIL %s wr_done pulses: got %0d want 1", name, pulses);
            end
            checks++;
            if (done_at != exp_done) begin
                errors++;
                $display("FAIL %s wr_done cycle: got %0d want %0d", name, done_at, exp_done);
            end
        end
    endtask

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({b1.req_ready, b1.wr_ready, b1.busy, b1.rd_valid, b1.rd_last, b1.wr_done} !== 6'b0) begin
            errors++;
            $display("FAIL reset b1 flags: got %b want 000000",
                     {b1.req_ready, b1.wr_ready, b1.busy, b1.rd_valid, b1.rd_last, b1.wr_done});
        end
        checks++;
        if (b1.rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset rd_data: got %h want 00", b1.rd_data);
        end
        checks++;
        if ({b2.req_ready, b2.busy, b2.rd_valid} !== 3'b0) begin
            errors++;
            $display("FAIL reset b2 flags: got %b want 000", {b2.req_ready, b2.busy, b2.rd_valid});
        end
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (b1.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset release req_ready: got %b want 1", b1.req_ready);
        end
        tick();
    endtask

    task automatic test_read_zero();
        read_line(8'h00, 32'h0000_0000, "read_zero");
    endtask

    task automatic test_write_read();
        write_line(8'h12, 32'hA1A2_A3A4, 4, -1, 0, 8, "write_12");
        read_line(8'h10, 32'hA3A4_A1A2, "read_10");
        read_line(8'h11, 32'hA4A1_A2A3, "read_11");
    endtask

    task automatic test_write_stall();
        write_line(8'h21, 32'hB1B2_B3B4, 4, 2, 2, 10, "write_stall");
        read_line(8'h20, 32'hB4B1_B2B3, "read_stall");
    endtask

    task automatic test_single_beat();
        b2.req_valid = 1'b1;
        b2.req_write = 1'b1;
        b2.req_addr  = 8'hFF;
        tick();
        b2.req_valid = 1'b0;
        checks++;
        if (b2.wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL single wr_ready: got %b want 1", b2.wr_ready);
        end
        b2.wr_valid = 1'b1;
        b2.wr_data  = 8'h5C;
        tick();
        b2.wr_valid = 1'b0;
        checks++;
        if ({b2.wr_done, b2.busy, b2.req_ready} !== 3'b101) begin
            errors++;
            $display("FAIL single write done: got %b want 101", {b2.wr_done, b2.busy, b2.req_ready});
        end
        b2.req_valid = 1'b1;
        b2.req_write = 1'b0;
        tick();
        b2.req_valid = 1'b0;
        tick();
        checks++;
        if ({b2.rd_valid, b2.rd_last, b2.req_ready} !== 3'b110) begin
            errors++;
            $display("FAIL single beat flags: got %b want 110", {b2.rd_valid, b2.rd_last, b2.req_ready});
        end
        checks++;
        if (b2.rd_data !== 8'h5C) begin
            errors++;
            $display("FAIL single beat data: got %h want 5c", b2.rd_data);
        end
        tick();
        checks++;
        if ({b2.rd_valid, b2.rd_last, b2.req_ready} !== 3'b001) begin
            errors++;
            $display("FAIL single after flags: got %b want 001", {b2.rd_valid, b2.rd_last, b2.req_ready});
        end
        checks++;
        if (b2.rd_data !== 8'h5C) begin
            errors++;
            $display("FAIL single hold data: got %h want 5c", b2.rd_data);
        end
    endtask

    task automatic test_reset_mid_read();
        accept_req(1'b0, 8'h10, "reset_read");
        for (int n = 1; n <= 6; n++) tick();
        checks++;
        if ((b1.rd_valid !== 1'b1) || (b1.rd_data !== 8'hA4)) begin
            errors++;
            $display("FAIL reset_read beat2: got %b/%h want 1/a4", b1.rd_valid, b1.rd_data);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({b1.rd_valid, b1.rd_last, b1.req_ready, b1.busy} !== 4'b0) begin
            errors++;
            $display("FAIL reset_read flags: got %b want 0000",
                     {b1.rd_valid, b1.rd_last, b1.req_ready, b1.busy});
        end
        checks++;
        if (b1.rd_data !== 8'h00) begin
            errors++;
            $display("FAIL reset_read rd_data: got %h want 00", b1.rd_data);
        end
        tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (b1.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_read req_ready: got %b want 1", b1.req_ready);
        end
        for (int n = 1; n <= 5; n++) begin
            tick();
            checks++;
            if ((b1.rd_valid !== 1'b0) || (b1.busy !== 1'b0)) begin
                errors++;
                $display("FAIL reset_read after n=%0d: got valid=%b busy=%b want 0/0", n, b1.rd_valid, b1.busy);
            end
        end
    endtask

    task automatic test_partial_write_reset();
        write_line(8'h30, 32'hC1C2_C3C4, 2, -1, 0, 0, "partial_write");
        rst_n = 1'b0;
        #1;
        checks++;
        if ((b1.wr_ready !== 1'b0) || (b1.busy !== 1'b0)) begin
            errors++;
            $display("FAIL partial_write reset: got wr_ready=%b busy=%b want 0/0", b1.wr_ready, b1.busy);
        end
        tick();
        rst_n = 1'b1;
        tick();
        read_line(8'h30, 32'hC1C2_0000, "partial_read");
    endtask

    task automatic test_back_to_back();
        int   accepts = 0;
        int   second_at = -1;
        int   waited = 0;
        logic acc;
        b1.req_valid = 1'b1;
        b1.req_write = 1'b0;
        b1.req_addr  = 8'h10;
        for (int e = 0; e <= 14; e++) begin
            acc = b1.req_valid && b1.req_ready;
            tick();
            if (acc) begin
                accepts++;
                if (e > 0) second_at = e;
            end
        end
        b1.req_valid = 1'b0;
        checks++;
        if (accepts != 2) begin
            errors++;
            $display("FAIL back_to_back accepts: got %0d want 2", accepts);
        end
        checks++;
        if (second_at != 10) begin
            errors++;
            $display("FAIL back_to_back second edge: got %0d want 10", second_at);
        end
        while ((b1.busy !== 1'b0) && (waited < 30)) begin
            tick();
            waited++;
        end
        checks++;
        if (b1.busy !== 1'b0) begin
            errors++;
            $display("FAIL back_to_back drain: got busy=%b want 0", b1.busy);
        end
    endtask

    initial begin
        b1.req_valid = 1'b0; b1.req_write = 1'b0; b1.req_addr = '0;
        b1.wr_valid  = 1'b0; b1.wr_data   = '0;
        b2.req_valid = 1'b0; b2.req_write = 1'b0; b2.req_addr = '0;
        b2.wr_valid  = 1'b0; b2.wr_data   = '0;
        test_reset();
        test_read_zero();
        test_write_read();
        test_write_stall();
        test_single_beat();
        test_reset_mid_read();
        test_partial_write_reset();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
